// File: rtl/isa_types_pkg.sv
// Shared hart types: access widths, memory map and the control bundle driven into the memory block.
package isa_types;
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RAM_START           = 32'h0000_0800;
    localparam logic [XLEN-1:0] INPUT_PERIPH_START  = 32'h0000_1000;
    localparam logic [XLEN-1:0] OUTPUT_PERIPH_START = 32'h0000_1800;
    localparam logic [XLEN-1:0] MEM_END             = 32'h0000_2000;

    typedef enum logic [1:0] {
        acc_byte = 2'd0,
        acc_half = 2'd1,
        acc_word = 2'd2
    } access_width_t;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        write_width_t    wwidth;
        logic [XLEN-1:0] wdata;
    } mem_control_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} lsu_state_t;

    function automatic write_width_t to_write_width(input access_width_t width);
        write_width_t ww;
        case (width)
            acc_byte: ww = write_byte;
            acc_half: ww = write_halfword;
            default:  ww = write_word;
        endcase
        return ww;
    endfunction

    // Stores may not touch ROM; loads may not read the write-only output peripherals.
    function automatic logic access_fault(input logic [XLEN-1:0] addr, input access_width_t width,
                                          input logic write);
        logic misaligned;
        misaligned = (width == acc_half && addr[0]) || (width == acc_word && addr[1:0] != 2'b00);
        return misaligned || (addr >= MEM_END) || (write && addr < RAM_START) ||
               (!write && addr >= OUTPUT_PERIPH_START);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response handshake plus the memory-block bus, as seen by the load/store unit.
interface load_store_unit_if;
    import isa_types::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    access_width_t   req_width;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;
    mem_control_t    mem_ctrl;
    logic [XLEN-1:0] mem_rdata;

    // Environment side: requester and memory block together.
    modport master (
        output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_ctrl
    );

    modport slave (
        input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_ctrl
    );
endinterface

// File: rtl/load_extend.sv
// Combinational width selection and sign/zero extension of captured load data.
module load_extend
    import isa_types::*;
(
    input  logic [XLEN-1:0] data,
    input  access_width_t   width,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);
    always_comb begin
        result = data;
        case (width)
            acc_byte: result = {{(XLEN-8){data[7] & ~is_unsigned}}, data[7:0]};
            acc_half: result = {{(XLEN-16){data[15] & ~is_unsigned}}, data[15:0]};
            default:  result = data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer: checks the request, drives the memory bus and returns
// a one-cycle response pulse with extended load data or a fault flag.
module load_store_unit
    import isa_types::*;
#(
    parameter int READ_LATENCY = 1  // 1..4
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    lsu_state_t      state, state_d;
    logic [1:0]      cnt, cnt_d;
    access_width_t   width, width_d;
    logic            is_unsigned, is_unsigned_d;
    logic            req_ready, req_ready_d;
    logic            resp_valid, resp_valid_d;
    logic [XLEN-1:0] resp_rdata, resp_rdata_d;
    logic            resp_fault, resp_fault_d;
    mem_control_t    mem_ctrl, mem_ctrl_d;
    logic [XLEN-1:0] ext_data;

    load_extend u_extend (
        .data        (bus.mem_rdata),
        .width       (width),
        .is_unsigned (is_unsigned),
        .result      (ext_data)
    );

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        width_d       = width;
        is_unsigned_d = is_unsigned;
        req_ready_d   = req_ready;
        resp_valid_d  = resp_valid;
        resp_rdata_d  = resp_rdata;
        resp_fault_d  = resp_fault;
        mem_ctrl_d    = mem_ctrl;
        case (state)
            IDLE: if (bus.req_valid && req_ready) begin
                width_d       = bus.req_width;
                is_unsigned_d = bus.req_unsigned;
                mem_ctrl_d.addr = bus.req_addr;
                req_ready_d   = 1'b0;
                if (access_fault(bus.req_addr, bus.req_width, bus.req_write)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else if (bus.req_write) begin
                    state_d            = WRITE;
                    mem_ctrl_d.wenable = 1'b1;
                    mem_ctrl_d.wwidth  = to_write_width(bus.req_width);
                    mem_ctrl_d.wdata   = bus.req_wdata;
                end else begin
                    state_d = READ_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            // Memory commits on the edge that leaves this state.
            WRITE: begin
                state_d            = RESP;
                mem_ctrl_d.wenable = 1'b0;
                resp_valid_d       = 1'b1;
            end
            READ_WAIT: begin
                if (cnt == 2'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ext_data;
                end else begin
                    cnt_d = cnt - 2'd1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
                resp_fault_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            width       <= acc_word;
            is_unsigned <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_fault  <= 1'b0;
            mem_ctrl    <= '{addr: '0, wenable: 1'b0, wwidth: write_word, wdata: '0};
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            width       <= width_d;
            is_unsigned <= is_unsigned_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_fault  <= resp_fault_d;
            mem_ctrl    <= mem_ctrl_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_fault = resp_fault;
    assign bus.mem_ctrl   = mem_ctrl;
endmodule

// File: tb/tb_load_store_unit.sv
// Two units (read latency 1 and 3) against a byte-array memory model and a reference memory image.
module tb_load_store_unit;
    import isa_types::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    logic         req_valid [2];
    logic         req_write [2];
    logic [1:0]   req_width [2];
    logic         req_unsigned [2];
    logic [31:0]  req_addr [2];
    logic [31:0]  req_wdata [2];
    logic         req_ready [2];
    logic         resp_valid [2];
    logic [31:0]  resp_rdata [2];
    logic         resp_fault [2];
    mem_control_t mem_ctrl [2];

    logic [7:0] ref_mem [2][8192];

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + (i >> 5));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int RL = (g == 0) ? 1 : 3;
        load_store_unit_if bus();

        assign bus.req_valid    = req_valid[g];
        assign bus.req_write    = req_write[g];
        assign bus.req_width    = access_width_t'(req_width[g]);
        assign bus.req_unsigned = req_unsigned[g];
        assign bus.req_addr     = req_addr[g];
        assign bus.req_wdata    = req_wdata[g];
        assign req_ready[g]     = bus.req_ready;
        assign resp_valid[g]    = bus.resp_valid;
        assign resp_rdata[g]    = bus.resp_rdata;
        assign resp_fault[g]    = bus.resp_fault;
        assign mem_ctrl[g]      = bus.mem_ctrl;

        load_store_unit #(.READ_LATENCY(RL)) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        // Memory: data for an address becomes valid RL cycles after it appears on mem_ctrl.
        logic [7:0]  m [8192];
        logic [31:0] ahist [1:3];
        logic [31:0] ra;
        initial for (int i = 0; i < 8192; i++) m[i] = init_byte(i);
        always @(posedge clock) begin
            ahist[1] <= bus.mem_ctrl.addr;
            ahist[2] <= ahist[1];
            ahist[3] <= ahist[2];
            if (bus.mem_ctrl.wenable) begin
                m[13'(bus.mem_ctrl.addr)] <= bus.mem_ctrl.wdata[7:0];
                if (bus.mem_ctrl.wwidth != write_byte)
                    m[13'(bus.mem_ctrl.addr + 1)] <= bus.mem_ctrl.wdata[15:8];
                if (bus.mem_ctrl.wwidth == write_word) begin
                    m[13'(bus.mem_ctrl.addr + 2)] <= bus.mem_ctrl.wdata[23:16];
                    m[13'(bus.mem_ctrl.addr + 3)] <= bus.mem_ctrl.wdata[31:24];
                end
            end
        end
        assign ra = (RL == 1) ? bus.mem_ctrl.addr : (RL == 2) ? ahist[1] :
                    (RL == 3) ? ahist[2] : ahist[3];
        assign bus.mem_rdata = {m[13'(ra + 3)], m[13'(ra + 2)], m[13'(ra + 1)], m[13'(ra)]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_store(input int ln, input int size, input logic [31:0] a,
                                      input logic [31:0] wd);
        for (int k = 0; k < size; k++) ref_mem[ln][13'(a + k)] = 8'(wd >> (8 * k));
    endfunction

    // Called at a negedge with the lane idle; returns at the negedge where the next request may go.
    task automatic xact(input int ln, input logic wr, input logic [1:0] w, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int rl, size, exp_lat, lat, pulses, wens, wen_cyc, bad_rdy;
        logic [31:0] v, got_rd, got_wd;
        logic got_f, exp_f;
        logic [1:0] got_ww, exp_ww;
        string t;
        rl   = (ln == 0) ? 1 : 3;
        size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        exp_f = (a % size != 0) || (a >= 32'h2000) || (wr && a < 32'h0800) || (!wr && a >= 32'h1800);
        exp_lat = exp_f ? 1 : (wr ? 2 : rl + 1);
        v = 0;
        if (!exp_f && !wr) begin
            for (int k = 0; k < size; k++) v = v | (32'(ref_mem[ln][13'(a + k)]) << (8 * k));
            if (!uns && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        end
        exp_ww = (size == 1) ? 2'(write_byte) : (size == 2) ? 2'(write_halfword) : 2'(write_word);
        t = $sformatf("L%0d %s w%0d u%0d a=%h", ln, wr ? "st" : "ld", w, uns, a);

        req_valid[ln] = 1'b1; req_write[ln] = wr; req_width[ln] = w;
        req_unsigned[ln] = uns; req_addr[ln] = a; req_wdata[ln] = wd;
        chk({t, " ready_idle"}, 32'(req_ready[ln]), 32'd1);
        @(posedge clock);
        @(negedge clock);
        lat = 0; pulses = 0; wens = 0; wen_cyc = 0; bad_rdy = 0;
        got_rd = '0; got_wd = '0; got_f = 1'b0; got_ww = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (resp_valid[ln]) begin
                pulses++;
                if (lat == 0) begin lat = cyc; got_rd = resp_rdata[ln]; got_f = resp_fault[ln]; end
            end
            if (mem_ctrl[ln].wenable) begin
                wens++; wen_cyc = cyc;
                got_ww = 2'(mem_ctrl[ln].wwidth); got_wd = mem_ctrl[ln].wdata;
            end
            if (lat != 0 && cyc > lat) begin
                chk({t, " ready_after"}, 32'(req_ready[ln]), 32'd1);
                break;
            end
            if (req_ready[ln]) bad_rdy++;
            // A busy unit must ignore a request presented while req_ready is low.
            if (lat != 0) req_valid[ln] = 1'b0;
            else begin
                req_valid[ln] = 1'b1; req_write[ln] = 1'b1; req_width[ln] = 2'd2;
                req_addr[ln] = 32'h0900; req_wdata[ln] = 32'hFFFF_FFFF;
            end
            @(negedge clock);
        end
        req_valid[ln] = 1'b0;
        chk({t, " latency"}, lat, exp_lat);
        chk({t, " pulses"}, pulses, 1);
        chk({t, " fault"}, 32'(got_f), 32'(exp_f));
        chk({t, " rdata"}, got_rd, v);
        chk({t, " busy_ready"}, bad_rdy, 0);
        chk({t, " wen_cycles"}, wens, (wr && !exp_f) ? 1 : 0);
        if (wr && !exp_f) begin
            chk({t, " wen_when"}, wen_cyc, 1);
            chk({t, " wwidth"}, 32'(got_ww), 32'(exp_ww));
            chk({t, " wdata"}, got_wd, wd);
            ref_store(ln, size, a, wd);
        end
    endtask

    task automatic reset_in_read(input int ln);
        int pulses;
        req_valid[ln] = 1'b1; req_write[ln] = 1'b0; req_width[ln] = 2'd2;
        req_unsigned[ln] = 1'b0; req_addr[ln] = 32'h0804;
        @(posedge clock);
        @(negedge clock);
        req_valid[ln] = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk($sformatf("L%0d rst_read ready", ln), 32'(req_ready[ln]), 32'd1);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid[ln]) pulses++;
            @(negedge clock);
        end
        chk($sformatf("L%0d rst_read no_resp", ln), pulses, 0);
    endtask

    task automatic reset_in_write(input int ln, input logic [31:0] a, input logic [31:0] wd);
        int pulses;
        req_valid[ln] = 1'b1; req_write[ln] = 1'b1; req_width[ln] = 2'd2;
        req_unsigned[ln] = 1'b0; req_addr[ln] = a; req_wdata[ln] = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid[ln] = 1'b0;
        chk($sformatf("L%0d rst_write wen", ln), 32'(mem_ctrl[ln].wenable), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ref_store(ln, 4, a, wd);
        chk($sformatf("L%0d rst_write wen_clr", ln), 32'(mem_ctrl[ln].wenable), 32'd0);
        chk($sformatf("L%0d rst_write ready", ln), 32'(req_ready[ln]), 32'd1);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid[ln]) pulses++;
            @(negedge clock);
        end
        chk($sformatf("L%0d rst_write no_resp", ln), pulses, 0);
    endtask

    task automatic random_xact(input int ln);
        logic wr, uns;
        logic [1:0] w;
        logic [31:0] a;
        int size, r;
        wr = 1'($urandom_range(0, 1));
        uns = 1'($urandom_range(0, 1));
        w = 2'($urandom_range(0, 2));
        size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        r = int'($urandom_range(0, 9));
        if (r <= 5)      a = 32'h0800 + $urandom_range(0, 32'h7FF);
        else if (r == 6) a = $urandom_range(0, 32'h7FF);
        else if (r == 7) a = 32'h1000 + $urandom_range(0, 32'h7FF);
        else if (r == 8) a = 32'h1800 + $urandom_range(0, 32'h7FF);
        else             a = ($urandom_range(0, 1) != 0) ? 32'h1FF8 + $urandom_range(0, 15) : $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
        xact(ln, wr, w, uns, a, $urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 8192; i++) ref_mem[ln][i] = init_byte(i);
            req_valid[ln] = 1'b0; req_write[ln] = 1'b0; req_width[ln] = 2'd0;
            req_unsigned[ln] = 1'b0; req_addr[ln] = '0; req_wdata[ln] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int ln = 0; ln < 2; ln++) begin
            chk($sformatf("L%0d rst ready", ln), 32'(req_ready[ln]), 32'd1);
            chk($sformatf("L%0d rst resp_valid", ln), 32'(resp_valid[ln]), 32'd0);
            chk($sformatf("L%0d rst resp_rdata", ln), resp_rdata[ln], 32'd0);
            chk($sformatf("L%0d rst resp_fault", ln), 32'(resp_fault[ln]), 32'd0);
            chk($sformatf("L%0d rst addr", ln), mem_ctrl[ln].addr, 32'd0);
            chk($sformatf("L%0d rst wenable", ln), 32'(mem_ctrl[ln].wenable), 32'd0);
            chk($sformatf("L%0d rst wwidth", ln), 32'(mem_ctrl[ln].wwidth), 32'(write_word));
            chk($sformatf("L%0d rst wdata", ln), mem_ctrl[ln].wdata, 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        for (int ln = 0; ln < 2; ln++) begin
            xact(ln, 1'b1, 2'd2, 1'b0, 32'h0804, 32'hDEAD_BEEF);
            xact(ln, 1'b0, 2'd2, 1'b0, 32'h0804, 32'h0);
            xact(ln, 1'b1, 2'd0, 1'b0, 32'h0801, 32'h0000_0080);
            xact(ln, 1'b0, 2'd0, 1'b0, 32'h0801, 32'h0);
            xact(ln, 1'b0, 2'd0, 1'b1, 32'h0801, 32'h0);
            xact(ln, 1'b1, 2'd1, 1'b0, 32'h0802, 32'h1234_ABCD);
            xact(ln, 1'b0, 2'd1, 1'b0, 32'h0802, 32'h0);
            xact(ln, 1'b1, 2'd2, 1'b0, 32'h0100, 32'h5555_5555);
            xact(ln, 1'b0, 2'd2, 1'b0, 32'h0806, 32'h0);
            xact(ln, 1'b0, 2'd0, 1'b0, 32'h1800, 32'h0);
            xact(ln, 1'b0, 2'd0, 1'b0, 32'h2000, 32'h0);
            xact(ln, 1'b0, 2'd2, 1'b0, 32'h0804, 32'h0);
            xact(ln, 1'b1, 2'd2, 1'b0, 32'h0808, 32'hCAFE_F00D);
            xact(ln, 1'b0, 2'd2, 1'b0, 32'h0808, 32'h0);
            reset_in_read(ln);
            reset_in_write(ln, 32'h0A00, 32'h0BAD_F00D ^ 32'(ln));
            xact(ln, 1'b0, 2'd2, 1'b0, 32'h0A00, 32'h0);
            for (int n = 0; n < 40; n++) random_xact(ln);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
